pipe_mips32_core: RTL and testbench

PIPE_MIPS32_CORE -- requirements
Module: pipe_mips32

---
 rtl/pipe_mips32_core.sv | 222 ++++++++++++++++++++++
 tb/tb_pipe_mips32_core.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_mips32_core.sv
// Five-stage MIPS32-subset pipeline (IF/ID/EX/MEM/WB) with a unified word-addressed memory,
// EX-stage operand forwarding, WB->ID write-through and branch resolution in EX.
module pipe_mips32_core (
    input  logic clk,
    input  logic rst_n,
    output logic halted
);
    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    localparam logic [DATA_W-1:0] NOP_IR = {6'b000111, 26'd0};

    typedef enum logic [2:0] {K_NOP, K_RR, K_RM, K_LW, K_SW, K_BR, K_HLT} kind_t;

    typedef struct packed {
        logic [DATA_W-1:0] ir;
        logic [DATA_W-1:0] npc;
    } if_id_t;

    typedef struct packed {
        kind_t             kind;
        logic [5:0]        op;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        dest;
        logic              wr;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] npc;
    } id_ex_t;

    typedef struct packed {
        kind_t             kind;
        logic [4:0]        dest;
        logic              wr;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] b;
    } ex_mem_t;

    typedef struct packed {
        logic              halt;
        logic [4:0]        dest;
        logic              wr;
        logic [DATA_W-1:0] result;
    } mem_wb_t;

    logic [DATA_W-1:0] Reg [0:31];
    logic [DATA_W-1:0] Mem [0:1023];
    logic [DATA_W-1:0] PC;
    logic              HALTED;
    logic              TAKEN_BRANCH;

    if_id_t  IF_ID;
    id_ex_t  ID_EX;
    ex_mem_t EX_MEM;
    mem_wb_t MEM_WB;

    id_ex_t            id_dec;
    ex_mem_t           ex_res;
    mem_wb_t           mem_res;
    logic [DATA_W-1:0] fa;
    logic [DATA_W-1:0] fb;
    logic              ex_taken;
    logic [DATA_W-1:0] ex_target;
    logic              drain;

    function automatic logic [DATA_W-1:0] alu(input logic [5:0] op,
                                              input logic signed [DATA_W-1:0] x,
                                              input logic signed [DATA_W-1:0] y);
        logic signed [DATA_W-1:0] r;
        r = '0;
        case (op)
            OP_ADD, OP_ADDI, OP_LW, OP_SW: r = x + y;
            OP_SUB, OP_SUBI:               r = x - y;
            OP_AND:                        r = x & y;
            OP_OR:                         r = x | y;
            OP_SLT, OP_SLTI:               r = {{(DATA_W-1){1'b0}}, (x < y)};
            OP_MUL:                        r = x * y;
            default:                       r = '0;
        endcase
        return r;
    endfunction

    assign halted = HALTED;

    // ID: decode and register read with same-cycle WB write-through
    always_comb begin
        id_dec     = '0;
        id_dec.op  = IF_ID.ir[31:26];
        id_dec.rs  = IF_ID.ir[25:21];
        id_dec.rt  = IF_ID.ir[20:16];
        id_dec.imm = {{16{IF_ID.ir[15]}}, IF_ID.ir[15:0]};
        id_dec.npc = IF_ID.npc;
        case (IF_ID.ir[31:26])
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: begin
                id_dec.kind = K_RR;
                id_dec.dest = IF_ID.ir[15:11];
            end
            OP_ADDI, OP_SUBI, OP_SLTI: begin
                id_dec.kind = K_RM;
                id_dec.dest = IF_ID.ir[20:16];
            end
            OP_LW: begin
                id_dec.kind = K_LW;
                id_dec.dest = IF_ID.ir[20:16];
            end
            OP_SW:             id_dec.kind = K_SW;
            OP_BNEQZ, OP_BEQZ: id_dec.kind = K_BR;
            OP_HLT:            id_dec.kind = K_HLT;
            default:           id_dec.kind = K_NOP;
        endcase
        id_dec.wr = ((id_dec.kind == K_RR) || (id_dec.kind == K_RM) || (id_dec.kind == K_LW))
                    && (id_dec.dest != 5'd0);
        if (id_dec.rs == 5'd0)
            id_dec.a = '0;
        else if (MEM_WB.wr && (MEM_WB.dest == id_dec.rs))
            id_dec.a = MEM_WB.result;
        else
            id_dec.a = Reg[id_dec.rs];
        if (id_dec.rt == 5'd0)
            id_dec.b = '0;
        else if (MEM_WB.wr && (MEM_WB.dest == id_dec.rt))
            id_dec.b = MEM_WB.result;
        else
            id_dec.b = Reg[id_dec.rt];
    end

    // EX: forwarding (EX_MEM is younger, so it wins), ALU and branch resolution
    always_comb begin
        fa = ID_EX.a;
        fb = ID_EX.b;
        if (EX_MEM.wr && (EX_MEM.kind != K_LW) && (EX_MEM.dest == ID_EX.rs))
            fa = EX_MEM.alu;
        else if (MEM_WB.wr && (MEM_WB.dest == ID_EX.rs))
            fa = MEM_WB.result;
        if (EX_MEM.wr && (EX_MEM.kind != K_LW) && (EX_MEM.dest == ID_EX.rt))
            fb = EX_MEM.alu;
        else if (MEM_WB.wr && (MEM_WB.dest == ID_EX.rt))
            fb = MEM_WB.result;

        ex_taken = 1'b0;
        if (ID_EX.kind == K_BR)
            ex_taken = (ID_EX.op == OP_BEQZ) ? (fa == '0) : (fa != '0);
        ex_target = ID_EX.npc + ID_EX.imm;

        ex_res      = '0;
        ex_res.kind = ID_EX.kind;
        ex_res.dest = ID_EX.dest;
        ex_res.wr   = ID_EX.wr;
        ex_res.alu  = alu(ID_EX.op, fa, (ID_EX.kind == K_RR) ? fb : ID_EX.imm);
        ex_res.b    = fb;
    end

    // MEM: combinational load path
    always_comb begin
        mem_res        = '0;
        mem_res.halt   = (EX_MEM.kind == K_HLT);
        mem_res.dest   = EX_MEM.dest;
        mem_res.wr     = EX_MEM.wr;
        mem_res.result = (EX_MEM.kind == K_LW) ? Mem[EX_MEM.alu[ADDR_W-1:0]] : EX_MEM.alu;
    end

    // Once HLT is decoded, nothing younger may enter the pipe.
    assign drain = (ID_EX.kind == K_HLT) || (EX_MEM.kind == K_HLT) || MEM_WB.halt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PC           <= '0;
            HALTED       <= 1'b0;
            TAKEN_BRANCH <= 1'b0;
            IF_ID.ir     <= NOP_IR;
            IF_ID.npc    <= '0;
            ID_EX        <= '0;
            EX_MEM       <= '0;
            MEM_WB       <= '0;
        end else if (!HALTED) begin
            TAKEN_BRANCH <= ex_taken;
            if (MEM_WB.halt)
                HALTED <= 1'b1;
            if (ex_taken) begin
                IF_ID.ir  <= Mem[ex_target[ADDR_W-1:0]];
                IF_ID.npc <= ex_target + 1'b1;
                PC        <= ex_target + 1'b1;
            end else if (drain) begin
                IF_ID.ir  <= NOP_IR;
                IF_ID.npc <= '0;
            end else begin
                IF_ID.ir  <= Mem[PC[ADDR_W-1:0]];
                IF_ID.npc <= PC + 1'b1;
                PC        <= PC + 1'b1;
            end
            ID_EX  <= (ex_taken || drain) ? id_ex_t'('0) : id_dec;
            EX_MEM <= ex_res;
            MEM_WB <= mem_res;
        end
    end

    // Architectural storage is never reset so preloaded contents survive rst_n.
    always_ff @(posedge clk) begin
        if (!HALTED && MEM_WB.wr)
            Reg[MEM_WB.dest] <= MEM_WB.result;
        if (!HALTED && (EX_MEM.kind == K_SW))
            Mem[EX_MEM.alu[ADDR_W-1:0]] <= EX_MEM.b;
    end

endmodule

// File: tb/tb_pipe_mips32_core.sv
// Directed bench for pipe_mips32_core: table of single-instruction ALU vectors plus
// hand-written programs for forwarding, load/store, branches, halt and mid-run reset.
module tb_pipe_mips32_core;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic halted;

    always #5 clk = ~clk;

    pipe_mips32_core dut (.clk(clk), .rst_n(rst_n), .halted(halted));

    localparam logic [5:0] OP_ADD = 6'b000000, OP_SUB = 6'b000001, OP_AND = 6'b000010;
    localparam logic [5:0] OP_OR = 6'b000011, OP_SLT = 6'b000100, OP_MUL = 6'b000101;
    localparam logic [5:0] OP_LW = 6'b001000, OP_SW = 6'b001001, OP_ADDI = 6'b001010;
    localparam logic [5:0] OP_SUBI = 6'b001011, OP_SLTI = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101, OP_BEQZ = 6'b001110;
    localparam logic [31:0] HLT = 32'hfc00_0000;
    localparam logic [31:0] NOP = 32'h1c00_0000;

    int n_chk = 0;
    int n_fail = 0;
    int pulses = 0;
    int prog_len = 0;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [4:0]  dreg;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [14];

    function automatic logic [31:0] rr(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [4:0] rd);
        return {op, rs, rt, rd, 11'd0};
    endfunction

    function automatic logic [31:0] ri(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic begin_prog();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_pc", dut.PC, 32'd0);
        chk("rst_halted_flag", {31'd0, dut.HALTED}, 32'd0);
        chk("rst_halted_port", {31'd0, halted}, 32'd0);
        chk("rst_taken", {31'd0, dut.TAKEN_BRANCH}, 32'd0);
        for (int i = 0; i < 1024; i++) dut.Mem[i] = 32'd0;
        for (int k = 0; k < 32; k++) dut.Reg[k] = k;
        pulses = 0;
        prog_len = 0;
    endtask

    task automatic put(input logic [31:0] w);
        dut.Mem[prog_len] = w;
        prog_len++;
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_to_halt(input string name, input int max_cycles);
        int c;
        c = 0;
        while (halted !== 1'b1 && c < max_cycles) begin
            @(posedge clk);
            #1;
            c++;
            if (dut.TAKEN_BRANCH === 1'b1) pulses++;
        end
        chk({name, "_halt_reached"}, {31'd0, halted}, 32'd1);
    endtask

    initial begin
        logic [31:0] pc_snap;

        vecs[0]  = '{"add_wrap",   rr(OP_ADD, 1, 2, 3), 32'h7fff_ffff, 32'h1, 5'd3, 32'h8000_0000};
        vecs[1]  = '{"sub_neg",    rr(OP_SUB, 1, 2, 3), 32'd5, 32'd7, 5'd3, 32'hffff_fffe};
        vecs[2]  = '{"and",        rr(OP_AND, 1, 2, 3), 32'hf0f0_1234, 32'h0ff0_ffff, 5'd3, 32'h00f0_1234};
        vecs[3]  = '{"or",         rr(OP_OR, 1, 2, 3), 32'hf000_0000, 32'h0000_000f, 5'd3, 32'hf000_000f};
        vecs[4]  = '{"slt_signed", rr(OP_SLT, 1, 2, 3), 32'hffff_ffff, 32'h1, 5'd3, 32'h1};
        vecs[5]  = '{"slt_false",  rr(OP_SLT, 1, 2, 3), 32'd5, 32'hffff_fff0, 5'd3, 32'h0};
        vecs[6]  = '{"mul_low",    rr(OP_MUL, 1, 2, 3), 32'h0001_0001, 32'h0001_0001, 5'd3, 32'h0002_0001};
        vecs[7]  = '{"mul_neg",    rr(OP_MUL, 1, 2, 3), 32'hffff_fffd, 32'd7, 5'd3, 32'hffff_ffeb};
        vecs[8]  = '{"addi_negimm", ri(OP_ADDI, 1, 3, 16'hfffe), 32'd10, 32'd0, 5'd3, 32'd8};
        vecs[9]  = '{"subi",       ri(OP_SUBI, 1, 3, 16'h0005), 32'd2, 32'd0, 5'd3, 32'hffff_fffd};
        vecs[10] = '{"slti_signed", ri(OP_SLTI, 1, 3, 16'hffff), 32'hffff_fffe, 32'd0, 5'd3, 32'h1};
        vecs[11] = '{"slti_false", ri(OP_SLTI, 1, 3, 16'h0003), 32'd5, 32'd0, 5'd3, 32'h0};
        vecs[12] = '{"write_r0",   rr(OP_ADD, 1, 2, 0), 32'd3, 32'd4, 5'd0, 32'h0};
        vecs[13] = '{"unknown_op", {6'b010000, 5'd1, 5'd2, 5'd3, 11'd0}, 32'd9, 32'd9, 5'd3, 32'd3};

        for (int i = 0; i < 14; i++) begin
            begin_prog();
            dut.Reg[1] = vecs[i].r1;
            dut.Reg[2] = vecs[i].r2;
            put(vecs[i].instr);
            put(HLT);
            release_rst();
            run_to_halt(vecs[i].name, 40);
            chk(vecs[i].name, dut.Reg[vecs[i].dreg], vecs[i].exp);
        end

        // Reference program: fixed 20-cycle run
        begin_prog();
        put(32'h2801000a); put(32'h28020014); put(32'h28030019);
        put(32'h0ce77800); put(32'h0ce77800); put(32'h00222000);
        put(32'h0ce77800); put(32'h00832800); put(32'hfc000000);
        release_rst();
        repeat (5) @(posedge clk);
        #1 chk("demo_not_halted_early", {31'd0, halted}, 32'd0);
        repeat (15) @(posedge clk);
        #1;
        chk("demo_halted", {31'd0, halted}, 32'd1);
        chk("demo_r0", dut.Reg[0], 32'd0);
        chk("demo_r1", dut.Reg[1], 32'd10);
        chk("demo_r2", dut.Reg[2], 32'd20);
        chk("demo_r3", dut.Reg[3], 32'd25);
        chk("demo_r4", dut.Reg[4], 32'd30);
        chk("demo_r5", dut.Reg[5], 32'd55);
        chk("demo_r15", dut.Reg[15], 32'd7);

        // Same program, reset asserted mid-run then re-executed
        begin_prog();
        put(32'h2801000a); put(32'h28020014); put(32'h28030019);
        put(32'h0ce77800); put(32'h0ce77800); put(32'h00222000);
        put(32'h0ce77800); put(32'h00832800); put(32'hfc000000);
        release_rst();
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_pc", dut.PC, 32'd0);
        chk("midrst_halted", {31'd0, halted}, 32'd0);
        chk("midrst_keeps_reg", dut.Reg[1], 32'd10);
        chk("midrst_keeps_mem", dut.Mem[8], HLT);
        repeat (3) @(posedge clk);
        #1 chk("midrst_pc_held", dut.PC, 32'd0);
        dut.Reg[5] = 32'd5;
        release_rst();
        run_to_halt("midrst", 40);
        chk("midrst_r1", dut.Reg[1], 32'd10);
        chk("midrst_r4", dut.Reg[4], 32'd30);
        chk("midrst_r5", dut.Reg[5], 32'd55);

        // Back-to-back dependency via EX_MEM forwarding
        begin_prog();
        put(ri(OP_ADDI, 0, 1, 16'd5));
        put(rr(OP_ADD, 1, 1, 2));
        put(HLT);
        release_rst();
        run_to_halt("fwd1", 40);
        chk("fwd1_r2", dut.Reg[2], 32'd10);

        // Distance-3 dependency through WB->ID write-through
        begin_prog();
        put(ri(OP_ADDI, 0, 1, 16'd4));
        put(NOP);
        put(NOP);
        put(rr(OP_ADD, 1, 1, 2));
        put(HLT);
        release_rst();
        run_to_halt("wthru", 40);
        chk("wthru_r2", dut.Reg[2], 32'd8);

        // Load, dependent ADDI, store of forwarded value
        begin_prog();
        dut.Mem[100] = 32'd7;
        put(ri(OP_LW, 0, 2, 16'd100));
        put(NOP);
        put(ri(OP_ADDI, 2, 3, 16'd1));
        put(ri(OP_SW, 0, 3, 16'd101));
        put(HLT);
        release_rst();
        run_to_halt("ldst", 40);
        chk("ldst_r2", dut.Reg[2], 32'd7);
        chk("ldst_r3", dut.Reg[3], 32'd8);
        chk("ldst_mem101", dut.Mem[101], 32'd8);

        // Taken BEQZ skips two ADDIs
        begin_prog();
        dut.Reg[1] = 32'd0;
        put(ri(OP_BEQZ, 1, 0, 16'd2));
        put(ri(OP_ADDI, 0, 5, 16'd1));
        put(ri(OP_ADDI, 0, 5, 16'd2));
        put(ri(OP_ADDI, 0, 6, 16'd9));
        put(HLT);
        release_rst();
        run_to_halt("beqz", 40);
        chk("beqz_r5", dut.Reg[5], 32'd5);
        chk("beqz_r6", dut.Reg[6], 32'd9);
        chk("beqz_pulses", pulses, 32'd1);

        // Not-taken BNEQZ falls through
        begin_prog();
        dut.Reg[1] = 32'd0;
        put(ri(OP_BNEQZ, 1, 0, 16'd2));
        put(ri(OP_ADDI, 0, 5, 16'd1));
        put(ri(OP_ADDI, 0, 5, 16'd2));
        put(ri(OP_ADDI, 0, 6, 16'd9));
        put(HLT);
        release_rst();
        run_to_halt("bneqz", 40);
        chk("bneqz_r5", dut.Reg[5], 32'd2);
        chk("bneqz_r6", dut.Reg[6], 32'd9);
        chk("bneqz_pulses", pulses, 32'd0);

        // Halt freeze: instructions after HLT never write
        begin_prog();
        put(ri(OP_ADDI, 0, 1, 16'd3));
        put(HLT);
        put(ri(OP_ADDI, 0, 7, 16'd77));
        put(ri(OP_SW, 0, 1, 16'd200));
        release_rst();
        run_to_halt("freeze", 40);
        pc_snap = dut.PC;
        repeat (10) @(posedge clk);
        #1;
        chk("freeze_pc", dut.PC, pc_snap);
        chk("freeze_halted", {31'd0, halted}, 32'd1);
        chk("freeze_r1", dut.Reg[1], 32'd3);
        chk("freeze_r7", dut.Reg[7], 32'd7);
        chk("freeze_mem200", dut.Mem[200], 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
